// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame width and the baud divisor
// calculation used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Clock cycles per line bit; zero baud rate yields 0 so the caller's range check trips.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return (baud_rate == 0) ? 0 : clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud divider: tick pulses for one cycle every DIV cycles, phase restarted by clear.
module uart_baud_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt + CW'(1);
    if (clear || (cnt == CW'(DIV - 1))) cnt_d = '0;
  end

  // tick is registered from the next count so it is high while cnt sits at DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      tick <= (cnt_d == CW'(DIV - 1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 1000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy,
  output logic      done
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD_RATE);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic [2:0]           bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic                 par, par_d;
  logic                 tx_d, busy_d, done_d, ready_q, ready_d;
  logic                 tick, clear;

  // Holding the divider cleared in IDLE restarts the bit phase at the accepting edge.
  assign clear        = (state == IDLE);
  assign bus.tx_ready = ready_q;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_d      = par;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          state_d    = START;
          shreg_d    = bus.tx_data;
          par_d      = (^bus.tx_data) ^ 1'(PARITY_ODD);
          bit_cnt_d  = 3'd0;
          stop_cnt_d = 1'b0;
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shreg_d   = {1'b0, shreg[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: begin
        if (tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the same edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      par      <= par_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10: four instances cover 8N1, 8E1, 8O1 and 8N2.
module tb_uart_tx;

  localparam int unsigned DIV = 10;
  localparam int NI = 4;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [11:0] bits;   // expected line bits, index 0 = start bit
    int         nbits;
    int         mode;    // 0: valid dropped after accept, 1: valid held with changing data
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NI-1:0] valid;
  logic [7:0]    data [NI];
  logic [NI-1:0] tx_w, busy_w, done_w, ready_w;

  int checks = 0;
  int errors = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_if bus ();
    assign bus.tx_valid = valid[g];
    assign bus.tx_data  = data[g];
    assign ready_w[g]   = bus.tx_ready;

    uart_tx #(
      .CLK_FREQ   (1000000),
      .BAUD_RATE  (100000),
      .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD ((g == 2) ? 1 : 0),
      .STOP_BITS  ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .tx   (tx_w[g]),
      .busy (busy_w[g]),
      .done (done_w[g])
    );
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic start_frame(input int inst, input logic [7:0] b);
    @(negedge clk);
    data[inst]  = b;
    valid[inst] = 1'b1;
    @(posedge clk);
  endtask

  // Checks one frame cycle by cycle starting in cycle 1 after the accepting edge.
  task automatic watch(input int inst, input logic [11:0] bits, input int nbits,
                       input int mode, input logic [7:0] nxt, input string tag);
    int last = nbits * int'(DIV);
    int tb = 0, bb = 0, rb = 0, db = 0, ib = 0, first = -1;
    logic exp_tx;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_tx = bits[(k - 1) / int'(DIV)];
      if (tx_w[inst] !== exp_tx) begin
        tb++;
        if (first < 0) first = k;
      end
      if (busy_w[inst] !== 1'b1)  bb++;
      if (ready_w[inst] !== 1'b0) rb++;
      if (done_w[inst] !== 1'b0)  db++;
      case (mode)
        0: valid[inst] = 1'b0;
        1: begin
          valid[inst] = (k < last);
          data[inst]  = 8'($urandom);
        end
        default: begin
          valid[inst] = 1'b1;
          data[inst]  = nxt;
        end
      endcase
    end
    check($sformatf("%s tx_bad_cycles first=%0d", tag, first), tb, 0);
    check($sformatf("%s busy_low_cycles", tag), bb, 0);
    check($sformatf("%s ready_high_cycles", tag), rb, 0);
    check($sformatf("%s early_done_cycles", tag), db, 0);
    @(negedge clk);
    check($sformatf("%s done_pulse", tag), int'(done_w[inst]), 1);
    check($sformatf("%s busy_at_done", tag), int'(busy_w[inst]), 0);
    check($sformatf("%s ready_at_done", tag), int'(ready_w[inst]), 1);
    check($sformatf("%s tx_at_done", tag), int'(tx_w[inst]), 1);
    if (mode != 2) begin
      valid[inst] = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done_w[inst] || busy_w[inst] || !tx_w[inst] || !ready_w[inst]) ib++;
      end
      check($sformatf("%s idle_after_bad_cycles", tag), ib, 0);
    end
  endtask

  initial begin
    int hb;
    valid = '0;
    for (int i = 0; i < NI; i++) data[i] = 8'h00;

    vecs[0] = '{0, 8'h55, 12'h2AA, 10, 0};
    vecs[1] = '{1, 8'h07, 12'h60E, 11, 0};
    vecs[2] = '{2, 8'h07, 12'h40E, 11, 0};
    vecs[3] = '{3, 8'hFF, 12'h7FE, 11, 0};
    vecs[4] = '{0, 8'h00, 12'h200, 10, 0};
    vecs[5] = '{1, 8'h80, 12'h700, 11, 0};
    vecs[6] = '{2, 8'h3C, 12'h678, 11, 0};
    vecs[7] = '{3, 8'hA5, 12'h74A, 11, 0};
    vecs[8] = '{0, 8'h96, 12'h32C, 10, 1};

    // Reset values before release, after a clock edge inside reset
    #12;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset tx[%0d]", i), int'(tx_w[i]), 1);
      check($sformatf("reset busy[%0d]", i), int'(busy_w[i]), 0);
      check($sformatf("reset done[%0d]", i), int'(done_w[i]), 0);
      check($sformatf("reset ready[%0d]", i), int'(ready_w[i]), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      start_frame(vecs[i].inst, vecs[i].data);
      watch(vecs[i].inst, vecs[i].bits, vecs[i].nbits, vecs[i].mode, 8'h00,
            $sformatf("vec%0d", i));
    end

    // Back-to-back: second byte accepted in the done cycle
    start_frame(0, 8'hA5);
    watch(0, 12'h34A, 10, 2, 8'h3C, "b2b_first");
    @(posedge clk);
    watch(0, 12'h278, 10, 0, 8'h00, "b2b_second");

    // Reset in cycle 45, in the middle of data bit 3
    start_frame(0, 8'h55);
    for (int k = 1; k <= 44; k++) @(negedge clk);
    check("pre_reset tx", int'(tx_w[0]), 0);
    check("pre_reset busy", int'(busy_w[0]), 1);
    rst = 1'b0;
    #1;
    check("async_reset tx", int'(tx_w[0]), 1);
    check("async_reset busy", int'(busy_w[0]), 0);
    check("async_reset ready", int'(ready_w[0]), 1);
    data[0]  = 8'h3C;
    valid[0] = 1'b1;
    hb = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0] || !tx_w[0]) hb++;
    end
    check("held_reset_bad_cycles", hb, 0);
    rst = 1'b1;
    @(posedge clk);
    watch(0, 12'h278, 10, 0, 8'h00, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
